// File: rtl/fetch_pkg.sv
// Shared types and constants for the Program_Rom fetch sequencer.
// Provides the FSM state enum, PC/row widths, sel_mem_0 encodings and
// the THUMB32 prefix check used to flag a 32-bit instruction pair.
package fetch_pkg;

    localparam int unsigned PC_W  = 15;
    localparam int unsigned ROW_W = 14;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned HW_W  = 16;

    // sel_mem_0 encodings; SEL0_IR1 and 2'd3 are reserved and never driven
    localparam logic [1:0] SEL0_DATA0 = 2'd0;
    localparam logic [1:0] SEL0_IR1   = 2'd1;
    localparam logic [1:0] SEL0_DATA1 = 2'd2;

    localparam logic [4:0] THUMB32_PFX_0 = 5'b11101;
    localparam logic [4:0] THUMB32_PFX_1 = 5'b11110;
    localparam logic [4:0] THUMB32_PFX_2 = 5'b11111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    // True when the top five bits of a halfword start a 32-bit instruction
    function automatic logic is_thumb32(input logic [4:0] pfx);
        return (pfx == THUMB32_PFX_0) || (pfx == THUMB32_PFX_1) ||
               (pfx == THUMB32_PFX_2);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer, the Program_Rom muxes and decode.
// master: the sequencer (drives ROM addressing and slot status).
// slave : ROM/decode side (drives consume/redirect commands and IR_0).
interface fetch_sequencer_if;
    import fetch_pkg::*;

    logic [1:0]       dec_consume;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic [HW_W-1:0]  ir_0;

    logic [ROW_W-1:0] rom_addr;
    logic             pc_1;
    logic             sel_mem_1;
    logic [1:0]       sel_mem_0;
    logic             slot0_valid;
    logic             slot1_valid;
    logic             pair_is_wide;
    logic [PC_W-1:0]  fetch_pc;
    logic             consume_err;

    modport master (
        input  dec_consume, redirect, redirect_pc, ir_0,
        output rom_addr, pc_1, sel_mem_1, sel_mem_0,
        output slot0_valid, slot1_valid, pair_is_wide, fetch_pc, consume_err
    );

    modport slave (
        output dec_consume, redirect, redirect_pc, ir_0,
        input  rom_addr, pc_1, sel_mem_1, sel_mem_0,
        input  slot0_valid, slot1_valid, pair_is_wide, fetch_pc, consume_err
    );

endinterface

// File: rtl/fetch_mux_ctrl.sv
// Combinational Program_Rom mux control from the PC parity bit.
// Ports: pc_lsb (pc[0]) -> pc_1 (bank-0 row increment), sel_mem_1, sel_mem_0.
// Even PC: IR_0=bank0, IR_1=bank1. Odd PC: IR_0=bank1, IR_1=bank0 row r+1.
module fetch_mux_ctrl
    import fetch_pkg::*;
(
    input  logic       pc_lsb,
    output logic       pc_1,
    output logic       sel_mem_1,
    output logic [1:0] sel_mem_0
);

    assign pc_1      = pc_lsb;
    assign sel_mem_1 = ~pc_lsb;
    assign sel_mem_0 = pc_lsb ? SEL0_DATA1 : SEL0_DATA0;

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch FSM for the dual-bank, dual-issue Program_Rom.
// Ports: clk, rst_n (async active-low), start (pulse), halt_req (level),
// bus (master): consume/redirect from decode, ROM row/mux controls,
// slot valids, wide-pair flag, fetch_pc and sticky consume_err.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned     ROM_ROWS     = 16384,
    parameter int unsigned     FLUSH_CYCLES = 1,
    parameter logic [PC_W-1:0] RESET_PC     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    fetch_sequencer_if.master bus
);

    localparam int unsigned      PC_SPAN    = 2 * ROM_ROWS;
    localparam int unsigned      SUM_W      = PC_W + 1;
    localparam logic [PC_W-1:0]  PC_MAX     = PC_W'(PC_SPAN - 1);
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d, last_pc_q, redirect_pc_mod;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             slot0_c, slot1_c;
    logic [1:0]       room, step;
    logic [SUM_W-1:0] pc_sum;
    logic             unused_ir;

    assign redirect_pc_mod = PC_W'(32'(bus.redirect_pc) % PC_SPAN);
    assign unused_ir       = ^{bus.ir_0[10:0]};

    // State, PC, flush counter and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            last_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (slot0_c) begin
                last_pc_q <= pc_q;
            end
        end
    end

    // Next-state, PC advance and slot status
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        slot0_c = (state_q == RUN);
        // bank-0 row r+1 does not exist past the last halfword
        slot1_c = slot0_c && (pc_q != PC_MAX);
        room    = slot1_c ? 2'd2 : 2'd1;
        step    = (bus.dec_consume > room) ? room : bus.dec_consume;
        pc_sum  = {1'b0, pc_q} + SUM_W'(step);

        case (state_q)
            IDLE, HALT: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (start) begin
                    state_d = RUN;
                    pc_d    = RESET_PC;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (bus.redirect) begin
                    state_d = FLUSH;
                    pc_d    = redirect_pc_mod;
                    cnt_d   = FLUSH_INIT;
                end else begin
                    if (bus.dec_consume > room) begin
                        err_d = 1'b1;
                    end
                    pc_d = (32'(pc_sum) >= PC_SPAN) ? PC_W'(32'(pc_sum) - PC_SPAN)
                                                    : PC_W'(pc_sum);
                end
            end
            FLUSH: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (bus.redirect) begin
                    pc_d  = redirect_pc_mod;
                    cnt_d = FLUSH_INIT;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rom_addr     = pc_q[PC_W-1:1];
    assign bus.slot0_valid  = slot0_c;
    assign bus.slot1_valid  = slot1_c;
    assign bus.pair_is_wide = slot0_c & slot1_c & is_thumb32(bus.ir_0[15:11]);
    assign bus.fetch_pc     = slot0_c ? pc_q : last_pc_q;
    assign bus.consume_err  = err_q;

    fetch_mux_ctrl u_mux_ctrl (
        .pc_lsb    (pc_q[0]),
        .pc_1      (bus.pc_1),
        .sel_mem_1 (bus.sel_mem_1),
        .sel_mem_0 (bus.sel_mem_0)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer against a behavioural
// model, with a combinational two-bank ROM built from the DUT mux controls.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam int unsigned FLUSH = 2;
    localparam int unsigned SPAN  = 32768;
    localparam int unsigned PCMAX = SPAN - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic halt_req = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    // behavioural model: mode 0 idle, 1 running, 2 halted; m_bub = bubbles left
    int unsigned m_mode, m_bub, m_pc, m_last;
    bit          m_err;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .ROM_ROWS     (16384),
        .FLUSH_CYCLES (FLUSH),
        .RESET_PC     (15'd0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .halt_req (halt_req),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    // Sample program: halfword address -> contents
    function automatic logic [15:0] hw(input int unsigned a);
        case (a)
            0:       return 16'h2014;
            1:       return 16'h2104;
            2:       return 16'h6008;
            8:       return 16'hF000;
            10:      return 16'hE7FE;
            default: return 16'(a * 32'h9E37 + (a >> 5) * 32'h1234);
        endcase
    endfunction

    // Two-bank ROM plus the output muxes, driven by the DUT controls
    logic [13:0] row0;
    logic [15:0] data_0, data_1, ir0_m, ir1_m;
    always_comb begin
        row0   = bus.rom_addr + 14'(bus.pc_1);
        data_0 = hw({17'd0, row0, 1'b0});
        data_1 = hw({17'd0, bus.rom_addr, 1'b1});
        if (bus.sel_mem_0 == SEL0_DATA0)      ir0_m = data_0;
        else if (bus.sel_mem_0 == SEL0_DATA1) ir0_m = data_1;
        else                                  ir0_m = 16'hDEAD;
        ir1_m = bus.sel_mem_1 ? data_1 : data_0;
    end
    assign bus.ir_0 = ir0_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_bub  = 0;
        m_pc   = 0;
        m_last = 0;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        int unsigned room, c;
        if (m_mode == 1 && m_bub == 0) m_last = m_pc;
        if (m_mode == 1) begin
            if (halt_req) begin
                m_mode = 2;
            end else if (bus.redirect) begin
                m_pc  = 32'(bus.redirect_pc) % SPAN;
                m_bub = FLUSH;
            end else if (m_bub > 0) begin
                m_bub = m_bub - 1;
            end else begin
                room = (m_pc == PCMAX) ? 1 : 2;
                c    = 32'(bus.dec_consume);
                if (c > room) begin
                    c     = room;
                    m_err = 1'b1;
                end
                m_pc = (m_pc + c) % SPAN;
            end
        end else if (halt_req) begin
            m_mode = 2;
        end else if (start) begin
            m_mode = 1;
            m_pc   = 0;
            m_bub  = 0;
            m_err  = 1'b0;
        end
    endtask

    // One clock: model advances on the rising edge, return at the falling edge
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic        act, two;
        logic [15:0] h;
        act = (m_mode == 1) && (m_bub == 0);
        two = act && (m_pc != PCMAX);
        h   = hw(m_pc);
        chk("slot0_valid", 32'(bus.slot0_valid), 32'(act));
        chk("slot1_valid", 32'(bus.slot1_valid), 32'(two));
        chk("rom_addr", 32'(bus.rom_addr), m_pc >> 1);
        chk("pc_1", 32'(bus.pc_1), m_pc & 1);
        chk("sel_mem_1", 32'(bus.sel_mem_1), 32'((m_pc & 1) == 0));
        chk("sel_mem_0", 32'(bus.sel_mem_0), ((m_pc & 1) != 0) ? 2 : 0);
        chk("ir_0", 32'(ir0_m), 32'(h));
        if (m_pc != PCMAX) chk("ir_1", 32'(ir1_m), 32'(hw(m_pc + 1)));
        chk("pair_is_wide", 32'(bus.pair_is_wide), 32'(two && (h[15:11] >= 5'b11101)));
        chk("fetch_pc", 32'(bus.fetch_pc), act ? m_pc : m_last);
        chk("consume_err", 32'(bus.consume_err), 32'(m_err));
    end

    initial begin
        logic [14:0] rp;
        bus.dec_consume = 2'd0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 15'd0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_slot0", 32'(bus.slot0_valid), 0);
        chk("rst_wide", 32'(bus.pair_is_wide), 0);
        chk("rst_sel1", 32'(bus.sel_mem_1), 1);
        chk("rst_err", 32'(bus.consume_err), 0);

        rst_n = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("start_slot1", 32'(bus.slot1_valid), 1);
        chk("start_sel0", 32'(bus.sel_mem_0), 0);
        chk("start_ir0", 32'(ir0_m), 32'h2014);
        chk("start_ir1", 32'(ir1_m), 32'h2104);

        bus.dec_consume = 2'd1;
        cycle();
        chk("odd_pc_1", 32'(bus.pc_1), 1);
        chk("odd_sel0", 32'(bus.sel_mem_0), 2);
        chk("odd_rom_addr", 32'(bus.rom_addr), 0);
        chk("odd_ir0", 32'(ir0_m), 32'h2104);
        chk("odd_ir1", 32'(ir1_m), 32'h6008);
        bus.dec_consume = 2'd2;
        cycle();
        chk("cons2_fetch_pc", 32'(bus.fetch_pc), 3);

        bus.dec_consume = 2'd0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 15'd5;
        cycle();
        bus.redirect = 1'b0;
        chk("bubble1_slot0", 32'(bus.slot0_valid), 0);
        chk("bubble1_fetch_pc", 32'(bus.fetch_pc), 3);
        cycle();
        chk("bubble2_slot0", 32'(bus.slot0_valid), 0);
        cycle();
        chk("redir_slot0", 32'(bus.slot0_valid), 1);
        chk("redir_fetch_pc", 32'(bus.fetch_pc), 5);
        chk("redir_rom_addr", 32'(bus.rom_addr), 2);
        chk("redir_pc_1", 32'(bus.pc_1), 1);

        bus.redirect    = 1'b1;
        bus.redirect_pc = 15'd8;
        cycle();
        bus.redirect = 1'b0;
        repeat (2) cycle();
        chk("wide_f000", 32'(bus.pair_is_wide), 1);
        bus.dec_consume = 2'd2;
        cycle();
        bus.dec_consume = 2'd0;
        chk("wide_e7fe_pc", 32'(bus.fetch_pc), 10);
        chk("wide_e7fe", 32'(bus.pair_is_wide), 0);

        bus.redirect    = 1'b1;
        bus.redirect_pc = 15'h7FFF;
        cycle();
        bus.redirect = 1'b0;
        repeat (2) cycle();
        chk("pcmax_slot0", 32'(bus.slot0_valid), 1);
        chk("pcmax_slot1", 32'(bus.slot1_valid), 0);
        bus.dec_consume = 2'd2;
        cycle();
        bus.dec_consume = 2'd0;
        chk("wrap_fetch_pc", 32'(bus.fetch_pc), 0);
        chk("wrap_err", 32'(bus.consume_err), 1);

        bus.dec_consume = 2'd1;
        cycle();
        bus.dec_consume = 2'd0;
        halt_req        = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 15'h0123;
        cycle();
        halt_req     = 1'b0;
        bus.redirect = 1'b0;
        chk("halt_slot0", 32'(bus.slot0_valid), 0);
        chk("halt_rom_addr", 32'(bus.rom_addr), 0);
        chk("halt_pc_1", 32'(bus.pc_1), 1);
        chk("halt_fetch_pc", 32'(bus.fetch_pc), 1);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("restart_fetch_pc", 32'(bus.fetch_pc), 0);
        chk("restart_err", 32'(bus.consume_err), 0);

        bus.dec_consume = 2'd2;
        cycle();
        bus.dec_consume = 2'd0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 15'h0040;
        cycle();
        bus.redirect = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_slot0", 32'(bus.slot0_valid), 0);
        chk("async_rst_rom_addr", 32'(bus.rom_addr), 0);
        chk("async_rst_pc_1", 32'(bus.pc_1), 0);
        chk("async_rst_fetch_pc", 32'(bus.fetch_pc), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            halt_req     = ($urandom_range(0, 24) == 0);
            start        = ($urandom_range(0, 9) == 0);
            bus.redirect = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 5))
                0:       rp = 15'h7FFF;
                1:       rp = 15'h7FFE;
                2:       rp = 15'(8 + 2 * $urandom_range(0, 1));
                default: rp = 15'($urandom);
            endcase
            bus.redirect_pc = rp;
            bus.dec_consume = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the dual-bank, dual-issue Program_Rom.
- Owns the halfword program counter and drives the ROM row address (Rom_addr_in), the odd-PC bank-0 increment (pc_1) and both output muxes (sel_mem_1, sel_mem_0), so IR_0 always holds the older halfword and IR_1 the younger one.
- Accepts consume and redirect commands from decode, inserts bubbles after branches, and supports start and halt.

Parameters:
- ROM_ROWS, 16384, rows per bank. The halfword space is 2*ROM_ROWS. PC_MAX = 2*ROM_ROWS-1.
- FLUSH_CYCLES, 1, bubble cycles after a redirect (range 1..7).
- RESET_PC, 0, halfword PC loaded on reset and on start.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse: leave IDLE/HALT, load RESET_PC.
- halt_req  in  1  level: enter HALT at the next edge.
- dec_consume  in  2  halfwords retired this cycle (0, 1 or 2).
- redirect  in  1  branch taken this cycle.
- redirect_pc  in  15  branch target, halfword address.
- ir_0  in  16  IR_0 from the ROM, used for 32-bit prefix detection.
- rom_addr  out  14  to Rom_addr_in, equals pc[14:1].
- pc_1  out  1  to pc_1, equals pc[0].
- sel_mem_1  out  1  to sel_mem_1.
- sel_mem_0  out  2  to sel_mem_0.
- slot0_valid  out  1  IR_0 is a valid instruction.
- slot1_valid  out  1  IR_1 is valid.
- pair_is_wide  out  1  IR_0/IR_1 together form one 32-bit instruction.
- fetch_pc  out  15  halfword PC of IR_0.
- consume_err  out  1  sticky flag: decode over-consumed.

Behaviour:
- Bank map:
  - Bank 0 (data_0) row r holds halfword 2r.
  - Bank 1 (data_1) row r holds halfword 2r+1.
- Mux control is purely combinational from pc[0]:
  - pc even: sel_mem_1=1, sel_mem_0=0 (IR_0=bank0 row r, IR_1=bank1 row r).
  - pc odd: sel_mem_1=0, sel_mem_0=2 (IR_0=bank1 row r, IR_1=bank0 row r+1 via pc_1).
  - sel_mem_0 values 1 and 3 are reserved and never driven.
- The ROM is combinational, so IR_0/IR_1 are valid in the same cycle as rom_addr. Fetch latency is 0 cycles from the PC register.
- States (2-bit register): IDLE, RUN, FLUSH, HALT.
- Reset (rst_n low, asynchronous):
  - State=IDLE, pc=RESET_PC, flush counter=0, consume_err=0.
  - Valids=0, pair_is_wide=0. Mux outputs follow pc.
- IDLE:
  - Valids 0.
  - start -> RUN with pc=RESET_PC.
  - halt_req in IDLE -> HALT.
- RUN:
  - slot0_valid=1. slot1_valid=1 unless pc==PC_MAX, where bank-0 row r+1 does not exist.
  - Transition priority: halt_req > redirect > consume.
  - halt_req -> HALT. pc holds.
  - redirect -> pc=redirect_pc mod 2*ROM_ROWS, counter=FLUSH_CYCLES-1, go to FLUSH. dec_consume is ignored that cycle.
  - Otherwise pc = pc + dec_consume, mod 2*ROM_ROWS (wraps PC_MAX+1 -> 0).
  - If dec_consume exceeds the number of valid slots, clamp to that number and set consume_err. Encoding 3 counts as over-consume and clamps to 2.
- FLUSH:
  - Valids 0. dec_consume is ignored.
  - Counter decrements each cycle. At 0 -> RUN.
  - A redirect in FLUSH reloads pc and the counter.
  - halt_req -> HALT.
- HALT:
  - Valids 0. pc frozen.
  - start -> RUN with pc=RESET_PC.
  - halt_req must be low for start to take effect.
- Wide detection:
  - pair_is_wide = slot0_valid & slot1_valid & (ir_0[15:11] in {11101, 11110, 11111}).
  - If the prefix is seen with slot1_valid=0, slots are still reported and decode must consume 0 or 1.
  - When pair_is_wide=1, decode must consume 2. A consume of 1 is legal but sets nothing.
- fetch_pc = pc whenever slot0_valid=1, otherwise it holds the last pc.
- consume_err clears only on reset or on start.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum (IDLE, RUN, FLUSH, HALT).
  - PC_W=15, ROW_W=14.
  - SEL0_DATA0=2'd0, SEL0_IR1=2'd1, SEL0_DATA1=2'd2.
  - THUMB32 prefix constants.
- One sub-module: fetch_mux_ctrl. It is combinational, pc[0] -> {pc_1, sel_mem_1, sel_mem_0}, and is reused by the ROM bench.
- The state machine, PC and counter live in fetch_sequencer.

Test Plan:
- Reset, then start, pc=0: rom_addr=0, pc_1=0, sel_mem_1=1, sel_mem_0=0, both valid. IR_0=0x2014 and IR_1=0x2104 with the sample ROM.
- dec_consume=1 from pc=0 -> pc=1: rom_addr=0, pc_1=1, sel_mem_1=0, sel_mem_0=2, IR_0=0x2104, IR_1=0x6008. Then consume=2 -> pc=3, fetch_pc=3.
- redirect with redirect_pc=5, FLUSH_CYCLES=2 -> valids 0 for exactly 2 cycles, then RUN with fetch_pc=5, rom_addr=2, pc_1=1.
- pc=PC_MAX in RUN -> slot1_valid=0. consume=2 -> pc=0 (clamped to 1, wraps), consume_err=1.
- ir_0=0xF000 with both slots valid -> pair_is_wide=1. ir_0=0xE7FE -> pair_is_wide=0.
- halt_req and redirect in the same cycle -> HALT, pc unchanged. rst_n low mid-FLUSH -> IDLE, pc=0, asynchronously without a clock edge.
